// File: rtl/otter_cu_pkg.sv
// Shared types for the OTTER multicycle control unit and decoder.
package otter_cu_pkg;

  // Control FSM states.
  typedef enum logic [2:0] {
    StInit,
    StFetch,
    StExec,
    StMemWait,
    StWb,
    StIntr
  } state_t;

  // RV32I major opcodes, ir[6:0].
  typedef enum logic [6:0] {
    OpLui    = 7'b0110111,
    OpAuipc  = 7'b0010111,
    OpJal    = 7'b1101111,
    OpJalr   = 7'b1100111,
    OpBranch = 7'b1100011,
    OpLoad   = 7'b0000011,
    OpStore  = 7'b0100011,
    OpOpImm  = 7'b0010011,
    OpOp     = 7'b0110011,
    OpSystem = 7'b1110011
  } opcode_t;

  // Instructions that write rd and finish in a single execute cycle.
  function automatic logic is_rd_single(opcode_t op);
    logic hit;
    hit = 1'b0;
    case (op)
      OpLui, OpAuipc, OpOpImm, OpOp, OpJal, OpJalr: hit = 1'b1;
      default:                                      hit = 1'b0;
    endcase
    return hit;
  endfunction

  // Instructions that use the data memory port.
  function automatic logic is_mem(opcode_t op);
    return (op == OpLoad) || (op == OpStore);
  endfunction

endpackage

// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: sequences fetch/execute/memory-wait/writeback,
// latches interrupt requests and counts retired instructions.
module otter_cu_fsm
  import otter_cu_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [6:0]       OPCODE,
  input  logic [2:0]       FUNCT3,
  input  logic             INTR,
  input  logic             MIE,
  input  logic             MEM_READY,
  output logic             PC_RST,
  output logic             PC_WRITE,
  output logic             REG_WR,
  output logic             MEM_RDEN1,
  output logic             MEM_RDEN2,
  output logic             MEM_WE2,
  output logic             CSR_WE,
  output logic             INT_TAKEN,
  output logic             MRET_EXEC,
  output logic             ILLEGAL,
  output logic [CNT_W-1:0] INSTRET
);

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             complete;
  logic             irq_now;
  opcode_t          op;

  assign op      = opcode_t'(OPCODE);
  // A request arriving in the completing cycle is still honoured at that boundary.
  assign irq_now = pending_q | INTR;
  assign INSTRET = instret_q;

  // Next-state and Moore/Mealy control outputs from state, opcode and MEM_READY.
  always_comb begin
    state_d   = state_q;
    complete  = 1'b0;
    PC_RST    = 1'b0;
    PC_WRITE  = 1'b0;
    REG_WR    = 1'b0;
    MEM_RDEN1 = 1'b0;
    MEM_RDEN2 = 1'b0;
    MEM_WE2   = 1'b0;
    CSR_WE    = 1'b0;
    INT_TAKEN = 1'b0;
    MRET_EXEC = 1'b0;
    ILLEGAL   = 1'b0;

    unique case (state_q)
      StInit: begin
        PC_RST  = 1'b1;
        state_d = StFetch;
      end

      StFetch: begin
        MEM_RDEN1 = 1'b1;
        state_d   = StExec;
      end

      StExec: begin
        if (is_rd_single(op)) begin
          REG_WR   = 1'b1;
          PC_WRITE = 1'b1;
          complete = 1'b1;
        end else begin
          case (op)
            OpBranch: begin
              PC_WRITE = 1'b1;
              complete = 1'b1;
            end
            OpLoad: begin
              MEM_RDEN2 = 1'b1;
              state_d   = MEM_READY ? StWb : StMemWait;
            end
            OpStore: begin
              MEM_WE2 = 1'b1;
              if (MEM_READY) begin
                PC_WRITE = 1'b1;
                complete = 1'b1;
              end else begin
                state_d = StMemWait;
              end
            end
            OpSystem: begin
              PC_WRITE = 1'b1;
              complete = 1'b1;
              if (FUNCT3 != 3'b000) begin
                REG_WR = 1'b1;
                CSR_WE = 1'b1;
              end else begin
                // funct3 == 0 in SYSTEM is treated as MRET.
                MRET_EXEC = 1'b1;
              end
            end
            default: begin
              // Unrecognised opcode: skip it without any architectural write.
              ILLEGAL  = 1'b1;
              PC_WRITE = 1'b1;
              complete = 1'b1;
            end
          endcase
        end
      end

      StMemWait: begin
        // Only loads and stores reach this state; anything else is handled as a store.
        if (op == OpLoad) begin
          MEM_RDEN2 = 1'b1;
          if (MEM_READY) state_d = StWb;
        end else begin
          MEM_WE2 = 1'b1;
          if (MEM_READY) begin
            PC_WRITE = 1'b1;
            complete = 1'b1;
          end
        end
      end

      StWb: begin
        REG_WR   = 1'b1;
        PC_WRITE = 1'b1;
        complete = 1'b1;
      end

      StIntr: begin
        INT_TAKEN = 1'b1;
        PC_WRITE  = 1'b1;
        state_d   = StFetch;
      end

      default: begin
        state_d = StInit;
      end
    endcase

    if (complete) begin
      state_d = (irq_now && MIE) ? StIntr : StFetch;
    end
  end

  // Pending interrupt and retired-instruction counter next state.
  always_comb begin
    // Clearing on interrupt entry beats a same-cycle request.
    pending_d = (state_q == StIntr) ? 1'b0 : irq_now;
    instret_d = complete ? instret_q + CNT_W'(1) : instret_q;
  end

  // State, pending flag and counter registers with asynchronous reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= StInit;
      pending_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      instret_q <= instret_d;
    end
  end

  // Elaboration-time sanity on the counter width.
  if (CNT_W < 1) begin : g_bad_width
    $error("CNT_W must be at least 1");
  end

endmodule

// File: doc/otter_cu_fsm.md
# otter_cu_fsm

Multicycle control state machine for the OTTER RV32I core. It sequences fetch, execute, memory-wait, writeback and interrupt entry by driving the PC write, register-file write and memory enables that the top level currently ties to constants. It works alongside the combinational decoder, which selects muxes and PC source. It also latches external interrupts and counts retired instructions.

## Interface
- `CNT_W`, default 32: width of the retired-instruction counter.
- `CLK` in 1: system clock, rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `OPCODE` in 7: `ir[6:0]`.
- `FUNCT3` in 3: `ir[14:12]`.
- `INTR` in 1: external interrupt request, synchronous to `CLK`, level or pulse.
- `MIE` in 1: machine interrupt enable, from the CSR file.
- `MEM_READY` in 1: data-port completion. High means the current load or store finishes this cycle.
- `PC_RST` out 1: PC reset.
- `PC_WRITE` out 1: PC load enable.
- `REG_WR` out 1: register-file write enable.
- `MEM_RDEN1` out 1: instruction read enable.
- `MEM_RDEN2` out 1: data read enable.
- `MEM_WE2` out 1: data write enable.
- `CSR_WE` out 1: CSR write enable.
- `INT_TAKEN` out 1: interrupt entry. Also steers the decoder to MTVEC.
- `MRET_EXEC` out 1: return from interrupt. Also steers the decoder to MEPC.
- `ILLEGAL` out 1: one-cycle flag for an unrecognised opcode.
- `INSTRET` out `CNT_W`: retired-instruction count.

## Operation
- **States:** `INIT`, `FETCH`, `EXEC`, `MEM_WAIT`, `WB`, `INTR`. The state register resets asynchronously to `INIT`.
- **Output style:** outputs are combinational from state plus opcode. Any output not listed for a state is 0.
- **INIT:** `PC_RST`=1. Next state is `FETCH`.
- **FETCH:** `MEM_RDEN1`=1. Next state is `EXEC`.
- **EXEC, by opcode:**
  - LUI, AUIPC, OP_IMM, OP, JAL, JALR: `REG_WR`=1, `PC_WRITE`=1. The instruction completes.
  - BRANCH: `PC_WRITE`=1. The instruction completes.
  - LOAD (`0000011`): `MEM_RDEN2`=1. If `MEM_READY`, next state is `WB`; otherwise `MEM_WAIT`.
  - STORE (`0100011`): `MEM_WE2`=1. If `MEM_READY`, `PC_WRITE`=1 and the instruction completes; otherwise next state is `MEM_WAIT`.
  - SYSTEM with `FUNCT3`≠0: `REG_WR`=1, `CSR_WE`=1, `PC_WRITE`=1. The instruction completes.
  - SYSTEM with `FUNCT3`=0: treated as MRET. `MRET_EXEC`=1, `PC_WRITE`=1. The instruction completes.
  - Any other opcode: `ILLEGAL`=1, `PC_WRITE`=1. No register, CSR or memory write. The instruction completes.
- **MEM_WAIT:**
  - Re-asserts `MEM_RDEN2` (load) or `MEM_WE2` (store) every cycle until `MEM_READY`.
  - Load on ready: next state is `WB`.
  - Store on ready: `PC_WRITE`=1 and the instruction completes.
- **WB:** `REG_WR`=1, `PC_WRITE`=1. The instruction completes.
- **On completion:**
  - If `pending` and `MIE`, next state is `INTR`; otherwise `FETCH`.
  - `INSTRET` increments by 1 and wraps modulo 2^`CNT_W`.
  - `ILLEGAL` and MRET instructions also count.
- **INTR:** `INT_TAKEN`=1, `PC_WRITE`=1, `pending` cleared. Next state is `FETCH`. Not counted in `INSTRET`.
- **Pending flag:**
  - Set on any cycle with `INTR`=1.
  - Held while `MIE`=0.
  - If `INTR` is high in the same cycle `INTR` state clears the flag, the clear wins. A level `INTR` re-sets it the following cycle.
- **Reset mid-operation:** `RST_N` low forces `INIT`, `pending`=0 and `INSTRET`=0 immediately, regardless of state or an outstanding `MEM_WAIT`.

## Timing
- **During reset and in INIT:** `PC_RST`=1. Every other output is 0 and `INSTRET`=0.
- **Non-memory instruction:** 2 cycles (`FETCH`, `EXEC`).
- **Store:** 2 cycles plus N wait cycles.
- **Load:** 3 cycles (`FETCH`, `EXEC`, `WB`) plus N wait cycles.
- **Interrupt entry:** adds 1 cycle after the completing instruction. Latency from `INTR` assertion to `INT_TAKEN` is at most one full instruction plus 1 cycle.
- **`MEM_READY`** is sampled only in `EXEC` for loads/stores and in `MEM_WAIT`. It is ignored elsewhere.
- **`PC_WRITE`** is high for exactly one cycle per instruction or interrupt.

## Structure
- **Package `otter_cu_pkg`:**
  - `state_t` enum covering the six states.
  - `opcode_t` enum: LUI `0110111`, AUIPC `0010111`, JAL `1101111`, JALR `1100111`, BRANCH `1100011`, LOAD `0000011`, STORE `0100011`, OP_IMM `0010011`, OP `0110011`, SYSTEM `1110011`.
  - The decoder imports the same package.
- **No sub-module.** The block is the state register, next-state/output logic, the pending flop and the counter.

## Test plan
- **Reset release:** hold `RST_N`=0 for 3 cycles, then release with OPCODE=OP → `PC_RST`=1 for 1 cycle, then `MEM_RDEN1`, then `REG_WR`+`PC_WRITE`; `INSTRET`=1.
- **Load with wait:** LOAD with `MEM_READY` low for 2 cycles → `MEM_RDEN2` high for 3 cycles, then `WB` with `REG_WR`=1; total 5 cycles.
- **Store:** STORE with `MEM_READY`=1 → `MEM_WE2`+`PC_WRITE` in `EXEC`, `REG_WR` never set; `INSTRET`+1.
- **Interrupt:** pulse `INTR` for 1 cycle mid-`EXEC` with `MIE`=1 → `INT_TAKEN`+`PC_WRITE` in the next cycle, then `FETCH`; with `MIE`=0 the request stays pending until `MIE` rises.
- **Illegal opcode:** OPCODE `1111111` → `ILLEGAL`=1 and `PC_WRITE`=1, with `REG_WR`, `MEM_WE2` and `CSR_WE` all 0.
- **Reset in MEM_WAIT, then wrap:** `RST_N` low during `MEM_WAIT` → `INIT` and `INSTRET`=0 asynchronously. Separately, with `CNT_W`=4, 16 instructions → `INSTRET` wraps to 0.
